// File: rtl/normalize_pipe_pkg.sv
// Shared FPU definitions for the normalisation pipeline: default widths,
// result flag bit positions and adder/subtractor mode encodings.
package normalize_pipe_pkg;

    localparam int MANT_W_DEF = 24;
    localparam int EXP_W_DEF  = 8;

    // out_flags = {sign_flip, zero, uflow, oflow}
    localparam int FLAG_W     = 4;
    localparam int FLAG_OFLOW = 0;
    localparam int FLAG_UFLOW = 1;
    localparam int FLAG_ZERO  = 2;
    localparam int FLAG_SIGN  = 3;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

endpackage

// File: rtl/normalize_pipe_lzc.sv
// Parametrised leading-zero counter: number of zeros above the most
// significant set bit, plus an all-zero indication.
module lzc #(
    parameter int  WIDTH = 24,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] count,
    output logic             all_zero
);

    // Scanning upward lets the highest set bit have the final word.
    always_comb begin
        count    = CNT_W'(WIDTH);
        all_zero = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if (data[i]) begin
                count    = CNT_W'(WIDTH - 1 - i);
                all_zero = 1'b0;
            end
        end
    end

endmodule

// File: rtl/normalize_pipe.sv
// Two-stage post-add normaliser: stage 1 negates/detects carry/counts leading
// zeros, stage 2 shifts, adjusts the exponent and raises the result flags.
module normalize_pipe
    import normalize_pipe_pkg::*;
#(
    parameter int MANT_W = MANT_W_DEF,
    parameter int EXP_W  = EXP_W_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mode,
    input  logic [MANT_W:0]   in_mag,
    input  logic [EXP_W-1:0]  in_exp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] out_sig,
    output logic [EXP_W-1:0]  out_exp,
    output logic [FLAG_W-1:0] out_flags
);

    localparam int               LZ_W     = $clog2(MANT_W + 1);
    localparam int               DIFF_W   = ((EXP_W > LZ_W) ? EXP_W : LZ_W) + 1;
    localparam logic [MANT_W:0]  MAG_ONE  = (MANT_W + 1)'(1);
    localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [EXP_W-1:0] EXP_OVF  = EXP_ONES - EXP_ONE;

    // Signed exp - lz; a non-positive value means a full normalising shift
    // would push the exponent out of the normal range.
    function automatic logic signed [DIFF_W-1:0] exp_less_lz(
        input logic [EXP_W-1:0] e,
        input logic [LZ_W-1:0]  lz
    );
        logic signed [DIFF_W-1:0] se;
        logic signed [DIFF_W-1:0] slz;
        se  = $signed(DIFF_W'(e));
        slz = $signed(DIFF_W'(lz));
        return se - slz;
    endfunction

    function automatic logic [EXP_W-1:0] dec_sat(input logic [EXP_W-1:0] e);
        return (e == '0) ? '0 : e - EXP_ONE;
    endfunction

    function automatic logic inc_ovf(input logic [EXP_W-1:0] e);
        return e >= EXP_OVF;
    endfunction

    logic vld_p1;
    logic vld_p2;
    logic adv_p2;
    logic en_p1;

    assign adv_p2    = !vld_p2 || out_ready;
    assign en_p1     = !vld_p1 || adv_p2;
    assign in_ready  = en_p1 && !RESET;
    assign out_valid = vld_p2;

    // ---- stage 1: negate, carry detect, leading-zero count ----
    logic            neg_p0;
    logic            carry_p0;
    logic [MANT_W:0] mag_p0;
    logic [LZ_W-1:0] lz_p0;
    logic            allz_p0;

    always_comb begin
        neg_p0   = (mode_e'(in_mode) == MODE_SUB) && in_mag[MANT_W];
        mag_p0   = neg_p0 ? (~in_mag + MAG_ONE) : in_mag;
        carry_p0 = mag_p0[MANT_W];
    end

    lzc #(.WIDTH(MANT_W)) u_lzc (
        .data     (mag_p0[MANT_W-1:0]),
        .count    (lz_p0),
        .all_zero (allz_p0)
    );

    logic [MANT_W:0]  mag_p1;
    logic [EXP_W-1:0] exp_p1;
    logic [LZ_W-1:0]  lz_p1;
    logic             zero_p1;
    logic             carry_p1;
    logic             sign_p1;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (en_p1) begin
                vld_p1 <= in_valid;
            end
            if (adv_p2) begin
                vld_p2 <= vld_p1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (in_valid && in_ready) begin
            mag_p1   <= mag_p0;
            exp_p1   <= in_exp;
            lz_p1    <= lz_p0;
            zero_p1  <= allz_p0 && !carry_p0;
            carry_p1 <= carry_p0;
            sign_p1  <= neg_p0;
        end
    end

    // ---- stage 2: shift, exponent adjust, flags ----
    logic signed [DIFF_W-1:0] diff_c;
    logic [MANT_W-1:0]        sig_c;
    logic [EXP_W-1:0]         exp_c;
    logic [FLAG_W-1:0]        flags_c;

    always_comb begin
        diff_c             = exp_less_lz(exp_p1, lz_p1);
        sig_c              = '0;
        exp_c              = '0;
        flags_c            = '0;
        flags_c[FLAG_SIGN] = sign_p1;
        if (zero_p1) begin
            flags_c[FLAG_ZERO] = 1'b1;
        end else if (carry_p1) begin
            if (inc_ovf(exp_p1)) begin
                exp_c               = EXP_ONES;
                flags_c[FLAG_OFLOW] = 1'b1;
            end else begin
                sig_c = mag_p1[MANT_W:1];
                exp_c = exp_p1 + EXP_ONE;
            end
        end else if (diff_c[DIFF_W-1] || (diff_c == '0)) begin
            // Denormal: shift only as far as the exponent allows.
            sig_c               = mag_p1[MANT_W-1:0] << dec_sat(exp_p1);
            flags_c[FLAG_UFLOW] = 1'b1;
        end else begin
            sig_c = mag_p1[MANT_W-1:0] << lz_p1;
            exp_c = diff_c[EXP_W-1:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            out_sig   <= '0;
            out_exp   <= '0;
            out_flags <= '0;
        end else if (adv_p2 && vld_p1) begin
            out_sig   <= sig_c;
            out_exp   <= exp_c;
            out_flags <= flags_c;
        end
    end

endmodule

// File: doc/normalize_pipe.md
NORMALIZE_PIPE -- requirements
Module: normalize_pipe

Interface
REQ-001 SHALL have parameters: MANT_W, 24, significand width including hidden bit; EXP_W, 8, exponent width.
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  input operand present.
REQ-005 SHALL have port in_ready  output  1  block accepts the operand this cycle.
REQ-006 SHALL have port in_mode  input  1  0 = ADD (bit MANT_W of in_mag is carry-out), 1 = SUB (in_mag is two's complement; bit MANT_W is sign).
REQ-007 SHALL have port in_mag  input  MANT_W+1  raw adder/subtractor result.
REQ-008 SHALL have port in_exp  input  EXP_W  pre-normalisation exponent.
REQ-009 SHALL have port out_valid  output  1  result present.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the result this cycle.
REQ-011 SHALL have port out_sig  output  MANT_W  normalised significand.
REQ-012 SHALL have port out_exp  output  EXP_W  adjusted exponent.
REQ-013 SHALL have port out_flags  output  4  {sign_flip, zero, uflow, oflow}.

Function
REQ-014 SHALL transfer input on in_valid && in_ready, and output on out_valid && out_ready.
REQ-015 SHALL have two pipeline stages: S1 does negate, carry and leading-zero count; S2 does shift, exponent adjust and flags.
REQ-016 SHALL produce out_valid exactly 2 cycles after acceptance when not stalled, sustaining 1 result per cycle.
REQ-017 SHALL advance each stage when it is empty or the next stage is advancing.
REQ-018 SHALL drive in_ready = !S1_valid || S1_advance.
REQ-019 SHALL hold S2 outputs stable while out_valid && !out_ready, with no loss or duplication.
REQ-020 In SUB mode with in_mag[MANT_W]=1, SHALL negate in_mag mod 2^(MANT_W+1) and set sign_flip.
REQ-021 In ADD mode with in_mag[MANT_W]=1, SHALL right-shift by 1, truncate the LSB, and compute exp+1.
REQ-022 When exp+1 reaches all-ones, SHALL output exp all-ones, sig 0, and oflow=1.
REQ-023 Otherwise, SHALL left-shift the magnitude by lz, the count of leading zeros above bit MANT_W-1, so that bit MANT_W-1 = 1, and compute exp-lz.
REQ-024 When lz >= in_exp, SHALL shift by max(in_exp-1,0) only, output exp 0, and set uflow=1 (denormal).
REQ-025 For zero magnitude, SHALL output sig 0, exp 0, zero=1, all other flags 0 except sign_flip.
REQ-026 A simultaneous transfer into and out of the same stage SHALL replace the contents without a bubble.

Reset
REQ-027 While RESET is high at a clock edge, SHALL clear both stage valid bits, out_sig, out_exp and out_flags to 0, and hold in_ready at 0.
REQ-028 An operand accepted in the cycle RESET asserts SHALL be discarded; mid-pipeline items SHALL be dropped.
REQ-029 in_ready SHALL be 1 in the first cycle after RESET deasserts.

Structure
REQ-030 A shared FPU package SHALL hold the default MANT_W/EXP_W, the flag bit indices and the mode encodings.
REQ-031 Leading-zero counting SHALL be one parametrised sub-module, lzc, returning count and all-zero.
REQ-032 The block SHALL contain no casex/priority tables sized to a fixed width.

Verification (MANT_W=24, EXP_W=8)
REQ-033 ADD, in_mag=25'h1000000, in_exp=8'h80 -> 2 cycles later out_sig=24'h800000, out_exp=8'h81, flags=0.
REQ-034 SUB, in_mag=25'h0000001, in_exp=8'h80 -> out_sig=24'h800000, out_exp=8'h69, flags=0; SUB, in_mag=25'h1FFFFFF -> same result with sign_flip=1.
REQ-035 SUB, in_mag=25'h0000001, in_exp=8'h05 -> out_sig=24'h000010, out_exp=0, uflow=1; in_mag=0 -> zero=1, sig 0, exp 0.
REQ-036 ADD, in_mag=25'h1000000, in_exp=8'hFE -> out_exp=8'hFF, out_sig=0, oflow=1.
REQ-037 Back-to-back stream of 8 operands, with out_ready low for 3 cycles mid-stream -> in_ready drops once both stages are full, and all 8 results emerge in order, unduplicated.
REQ-038 RESET pulsed with 2 items in flight -> out_valid=0 next cycle, neither item ever emitted.
